// File: rtl/mult_ctrl_unit.sv
// Control unit for the sequential shift-and-add multiplier:
// button conditioning, multiply FSM and display window select.

module mult_ctrl_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [7:0] CMAX = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_lvl;
  logic       r_lvl_d;
  logic [7:0] r_cnt;

  // two-flop synchroniser for the raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // accept a new level once it has disagreed for CMAX+1 clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lvl <= 1'b0;
      r_cnt <= 8'd0;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= 8'd0;
    end else if (r_cnt == CMAX) begin
      r_lvl <= r_s2;
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // previous accepted level, for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lvl_d <= 1'b0;
    else        r_lvl_d <= r_lvl;
  end

  assign o_pulse = r_lvl & ~r_lvl_d;

endmodule

module mult_ctrl_unit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic BTNC,
  input  logic BTNL,
  input  logic BTNR,
  input  logic z_flag,
  input  logic b0,
  output logic rst,
  output logic load,
  output logic enable,
  output logic Psel,
  output logic done,
  output logic sel_1,
  output logic sel_2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_sel;
  logic       w_pc;
  logic       w_pl;
  logic       w_pr;

  mult_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
    .clk(clk), .reset(reset), .i_btn(BTNC), .o_pulse(w_pc)
  );
  mult_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
    .clk(clk), .reset(reset), .i_btn(BTNL), .o_pulse(w_pl)
  );
  mult_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
    .clk(clk), .reset(reset), .i_btn(BTNR), .o_pulse(w_pr)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and datapath controls; RUN outputs follow z_flag/b0
  always_comb begin
    w_next = r_state;
    rst    = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    Psel   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        rst = 1'b1;
        if (w_pc) w_next = S_LOAD;
      end
      S_LOAD: begin
        load   = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        if (z_flag) begin
          w_next = S_DONE;
        end else begin
          enable = 1'b1;
          Psel   = b0;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (w_pc) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // window select: R steps up, L steps down, both cancel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_sel <= 2'd0;
    else if (w_pr && !w_pl) r_sel <= r_sel + 2'd1;
    else if (w_pl && !w_pr) r_sel <= r_sel - 2'd1;
  end

  assign sel_1 = r_sel[1];
  assign sel_2 = r_sel[0];

endmodule

// File: tb/tb_mult_ctrl_unit.sv
// Bench for mult_ctrl_unit: directed steps plus random
// stimulus checked against a queue-based behavioural model.

module tb_mult_ctrl_unit;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic BTNC = 1'b0;
  logic BTNL = 1'b0;
  logic BTNR = 1'b0;
  logic z_flag = 1'b0;
  logic b0 = 1'b0;
  logic rst, load, enable, Psel, done, sel_1, sel_2;

  int ncmp = 0;
  int nfail = 0;

  logic [6:0] o_last;

  mult_ctrl_unit #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
    .z_flag(z_flag), .b0(b0),
    .rst(rst), .load(load), .enable(enable),
    .Psel(Psel), .done(done),
    .sel_1(sel_1), .sel_2(sel_2)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 load, 2 run, 3 done
  int m_state;
  int m_sel;
  bit m_lvl[3];
  bit m_lvlp[3];
  bit rawq[3][$];
  bit syncq[3][$];

  function automatic void m_reset();
    m_state = 0;
    m_sel = 0;
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = 1'b0;
      m_lvlp[i] = 1'b0;
      rawq[i].delete();
      syncq[i].delete();
    end
  endfunction

  function automatic bit raw_in(int i);
    if (i == 0) return BTNC;
    if (i == 1) return BTNL;
    return BTNR;
  endfunction

  function automatic void m_tick();
    bit p[3];
    bit s;
    bit diff;
    for (int i = 0; i < 3; i++)
      p[i] = m_lvl[i] && !m_lvlp[i];
    case (m_state)
      0: if (p[0]) m_state = 1;
      1: m_state = 2;
      2: if (z_flag) m_state = 3;
      default: if (p[0]) m_state = 1;
    endcase
    if (p[2] && !p[1]) m_sel = (m_sel + 1) % 4;
    else if (p[1] && !p[2]) m_sel = (m_sel + 3) % 4;
    for (int i = 0; i < 3; i++) begin
      s = (rawq[i].size() >= 2) ? rawq[i][$-1] : 1'b0;
      syncq[i].push_back(s);
      rawq[i].push_back(raw_in(i));
      if (rawq[i].size() > 4) void'(rawq[i].pop_front());
      if (syncq[i].size() > 2 * D) void'(syncq[i].pop_front());
      m_lvlp[i] = m_lvl[i];
      if (syncq[i].size() >= D) begin
        diff = 1'b1;
        for (int k = 1; k <= D; k++)
          if (syncq[i][syncq[i].size() - k] == m_lvl[i]) diff = 1'b0;
        if (diff) m_lvl[i] = !m_lvl[i];
      end
    end
  endfunction

  function automatic logic [6:0] m_exp();
    logic [6:0] e;
    e[6] = (m_state == 0);
    e[5] = (m_state == 1);
    e[4] = (m_state == 2) && !z_flag;
    e[3] = (m_state == 2) && !z_flag && b0;
    e[2] = (m_state == 3);
    e[1:0] = 2'(m_sel);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [6:0] o,
                     input logic [6:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // one clock: drive, check outputs, advance model at the edge
  task automatic cyc(input bit c, input bit l, input bit r,
                     input bit z, input bit b);
    BTNC = c;
    BTNL = l;
    BTNR = r;
    z_flag = z;
    b0 = b;
    if (!reset) m_reset();
    #1;
    o_last = {rst, load, enable, Psel, done, sel_1, sel_2};
    chk("cycle", o_last, m_exp());
    @(posedge clk);
    if (!reset) m_reset();
    else m_tick();
    @(negedge clk);
  endtask

  int first_load;
  int nload;
  logic [1:0] sel_exp[4];
  bit bc, bl, br;

  initial begin
    m_reset();
    sel_exp[0] = 2'd1;
    sel_exp[1] = 2'd2;
    sel_exp[2] = 2'd3;
    sel_exp[3] = 2'd0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("reset_out", o_last, 7'b1000000);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    chk("idle_out", o_last, 7'b1000000);

    first_load = -1;
    nload = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (o_last[5]) begin
        nload++;
        if (first_load < 0) first_load = i;
      end
    end
    chk("load_latency", 7'(first_load), 7'(D + 3));
    chk("load_once", 7'(nload), 7'd1);
    chk("run_b0", 7'(o_last[4:3]), 7'b10);

    cyc(0, 0, 0, 0, 1);
    chk("psel_hi", 7'(o_last[4:3]), 7'b11);
    cyc(0, 0, 0, 0, 0);
    chk("psel_lo", 7'(o_last[4:3]), 7'b10);
    cyc(0, 0, 0, 1, 1);
    chk("zflag_stop", 7'(o_last[4:2]), 7'b000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("done_held", 7'(o_last[2]), 7'd1);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
      chk("sel_r", 7'(o_last[1:0]), 7'(sel_exp[n]));
    end
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("sel_l_wrap", 7'(o_last[1:0]), 7'd3);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("sel_both", 7'(o_last[1:0]), 7'd3);

    nload = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (o_last[5]) nload++;
    end
    chk("bounce_once", 7'(nload), 7'd1);
    chk("done_to_run", 7'(o_last[4]), 7'd1);

    reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("abort", o_last, 7'b1000000);
    cyc(0, 0, 0, 0, 0);
    reset = 1'b1;

    bc = 0;
    bl = 0;
    br = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) bc = !bc;
      if ($urandom_range(0, 11) == 0) bl = !bl;
      if ($urandom_range(0, 11) == 0) br = !br;
      reset = ($urandom_range(0, 299) != 0);
      cyc(bc, bl, br, $urandom_range(0, 5) == 0, 1'($urandom));
    end
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
